// File: rtl/io_uart_tx.sv
// ---------------------------------------------------------------------------
// io_uart_tx : byte-wide memory-mapped UART transmitter with a small FIFO.
//
// Register map (selected when i_IO_addr[7:4] == BASE_NIBBLE):
//   offset 0x0  THR  write-only, pushes i_IO_write[7:0] on the rising edge
//                    of i_IO_we (a held strobe pushes once)
//   offset 0x5  LSR  read-only : bit6 TEMT, bit5 THRE, bit1 OE
//
// Frame format is 8N1 by default. Defining the macro UART_TX_PARITY_EN
// adds an even parity bit between the data bits and the stop bit (8E1).
//
// Reset is synchronous and active-high. Asserting it mid-frame aborts the
// frame at once and drops everything still queued.
// ---------------------------------------------------------------------------
module io_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [3:0]  BASE_NIBBLE  = 4'h9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_IO_addr,
  input  logic [15:0] i_IO_write,
  input  logic        i_IO_be,
  input  logic        i_IO_we,
  input  logic        i_IO_re,
  output logic [15:0] o_IO_read,
  output logic        o_tx
);

  // -------------------------------------------------------------------------
  // Derived widths and constants
  // -------------------------------------------------------------------------
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CLK_W-1:0] CLK_LAST      = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFF_THR = 4'h0;
  localparam logic [3:0] OFF_LSR = 4'h5;

  // Transmit FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  logic             dev_sel;
  logic             thr_sel;
  logic             lsr_sel;
  logic             we_q;
  logic             re_q;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             oe_clr;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;

  logic             oe;
  logic             thre;
  logic             temt;

  logic [2:0]       state;
  logic [7:0]       shift;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic             tx_q;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  // Byte-enable and the upper write byte carry no information for byte-wide
  // registers; folding them here keeps them visibly intentional.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_IO_be, i_IO_write[15:8]};

  // -------------------------------------------------------------------------
  // Address decode and strobe edge detection
  // -------------------------------------------------------------------------
  assign dev_sel = (i_IO_addr[7:4] == BASE_NIBBLE);
  assign thr_sel = dev_sel && (i_IO_addr[3:0] == OFF_THR);
  assign lsr_sel = dev_sel && (i_IO_addr[3:0] == OFF_LSR);

  // A held write strobe must push exactly once, a held read clears OE once.
  assign push_req = thr_sel && i_IO_we && !we_q;
  assign oe_clr   = lsr_sel && i_IO_re && !re_q;

  // Remember last cycle's strobe levels for rising-edge detection.
  // NOTE: every clocked register uses non-blocking assignment so all flops
  // update together from pre-edge values; blocking here would create order-
  // dependent simulation and mismatch synthesis.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      we_q <= i_IO_we;
      re_q <= i_IO_re;
    end
  end

  // -------------------------------------------------------------------------
  // Transmit FIFO
  // -------------------------------------------------------------------------
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL_CNT);

  // The shifter drains the FIFO head whenever it is idle.
  assign pop = (state == ST_IDLE) && !fifo_empty;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = push_req && (!fifo_full || pop);

  // Storage array write port.
  // NOTE: the data array has no reset; validity is tracked by the pointers
  // and count, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_IO_write[7:0];
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overrun flag: set by a dropped push, cleared by a fresh LSR read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      oe <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      oe <= 1'b1;
    end else if (oe_clr) begin
      oe <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Status and read mux
  // -------------------------------------------------------------------------
  assign thre = !fifo_full;
  assign temt = fifo_empty && (state == ST_IDLE);

  // Read data is purely combinational on the offset; the OE clear takes
  // effect on the following edge, so the clearing read still shows OE = 1.
  // NOTE: the output gets a default before any condition so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    o_IO_read = 16'h0000;
    if (lsr_sel) begin
      o_IO_read = {8'h00, 1'b0, temt, thre, 3'b000, oe, 1'b0};
    end
  end

  // -------------------------------------------------------------------------
  // Transmit FSM and serializer
  // -------------------------------------------------------------------------
  assign bit_done = (clk_cnt == CLK_LAST);

  // Sequence one frame per FIFO entry; tx_q changes together with the state
  // so the line level always matches the bit being sent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      tx_q     <= 1'b1;
      shift    <= 8'h00;
      clk_cnt  <= '0;
      bit_idx  <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q    <= 1'b1;
          clk_cnt <= '0;
          bit_idx <= 3'd0;
          if (!fifo_empty) begin
            shift    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^mem[rd_ptr];
`endif
            tx_q     <= 1'b0;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_done) begin
            clk_cnt <= '0;
            tx_q    <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            state   <= ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= parity_q;
              state <= ST_PARITY;
`else
              tx_q  <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            clk_cnt <= '0;
            tx_q    <= 1'b1;
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_done) begin
            clk_cnt <= '0;
            tx_q    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          clk_cnt <= '0;
          tx_q    <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx = tx_q;

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, i_clk cycles per serial bit (50 MHz / 115200).
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, minimum 2.
REQ-003 Parameter BASE_NIBBLE, default 4'h9, value of i_IO_addr[7:4] that selects this device (0xff90-0xff9f).
REQ-004 Ports: one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_IO_addr  input  8  IO-space byte offset from the bus controller.
REQ-008 i_IO_write  input  16  write data; the byte written is in bits [7:0].
REQ-009 i_IO_be  input  1  byte access flag; accepted and ignored, since all registers are byte-wide.
REQ-010 i_IO_we  input  1  write strobe (level); may stay high for several cycles.
REQ-011 i_IO_re  input  1  read strobe (level).
REQ-012 o_IO_read  output  16  read data, zero-extended to 16 bits.
REQ-013 o_tx  output  1  serial line, idle high.

Function
REQ-014 Device is selected when i_IO_addr[7:4] == BASE_NIBBLE; register offset is i_IO_addr[3:0].
REQ-015 Offset 0x0 THR: on the first cycle a selected i_IO_we is high after being low (rising edge, registered), i_IO_write[7:0] is pushed to the FIFO; write is held high for more cycles -> no further push.
REQ-016 Offset 0x5 LSR read: bit0 = 0, bit1 = OE (overrun), bit5 = THRE (FIFO not full), bit6 = TEMT (FIFO empty and shifter idle); all other bits 0.
REQ-017 o_IO_read is combinational from the offset; it reads 16'h0000 for unselected or unmapped offsets and for THR.
REQ-018 A push while the FIFO is full is dropped and sets OE.
REQ-019 OE clears on the rising edge of a selected i_IO_re at offset 0x5; that read still returns OE = 1.
REQ-020 Simultaneous push and pop on a full FIFO: the pop happens first, the push is accepted, and OE is not set.
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
REQ-022 TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-023 IDLE: o_tx = 1; if the FIFO is not empty, pop the head into the shift register and enter START on the next cycle.
REQ-024 Each of START (o_tx = 0), DATA (8 bits, LSB first), PARITY and STOP (o_tx = 1) lasts exactly CLKS_PER_BIT cycles, timed by a bit counter.
REQ-025 After STOP, return to IDLE; with the FIFO not empty, the next START begins with no extra idle bit (1 cycle in IDLE allowed).
REQ-026 o_tx is driven from a register (glitch-free).

Reset
REQ-027 While i_rst is high: FIFO empty, pointers 0, OE = 0, FSM = IDLE, o_tx = 1, bit/sample counters 0, we/re edge registers 0.
REQ-028 Reset asserted mid-frame aborts the frame immediately: o_tx = 1 on the first cycle after reset is sampled, and queued data is discarded.
REQ-029 After reset, LSR reads 16'h0060.

Configuration
REQ-030 Macro UART_TX_PARITY_EN: when defined, the frame is 8E1 with an even parity bit (XOR of the data bits) sent in the PARITY state between DATA and STOP.
REQ-031 Without UART_TX_PARITY_EN: the frame is 8N1, the PARITY state is absent, and DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Reset, then read offset 0x95 -> o_IO_read = 16'h0060, o_tx = 1.
REQ-033 Write 0xA5 to 0x90 (we held high 3 cycles) -> exactly one frame: start 0, bits 1,0,1,0,0,1,0,1, (parity 0 if macro), stop 1; each bit 4 cycles.
REQ-034 Five back-to-back writes 0x01..0x05 while the first is not yet popped -> 0x05 dropped, LSR = 16'h0002; a second LSR read returns 16'h0000 (OE cleared) while the FIFO is still full.
REQ-035 Queue 0x11 and 0x22 -> the second frame's start bit follows the first stop bit within CLKS_PER_BIT+1 cycles; LSR = 16'h0060 after the final stop bit.
REQ-036 Assert i_rst during DATA of 0x3C -> o_tx = 1 the next cycle, no further frames, LSR = 16'h0060.
REQ-037 Write to offset 0x91, or with i_IO_addr[7:4] = 4'h8 -> no push, o_tx stays idle, and reads return 16'h0000.
